muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO result registers for the Simple MIPS datapath. It executes MULT, MULTU, DIV and DIVU over multiple cycles, in place of the single-cycle `alu`, which covers only AND/OR/ADD/MUL/SUB/SLT/shifts. It sits beside the `alu` in EX and receives operands from the register file read ports. The control unit stalls the pipeline on `busy`, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Only 32 is supported.
- `CNT_W`, 6, iteration counter width.

Ports:
- `clk_i`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src1`  in  32  rs operand (multiplicand / dividend).
- `src2`  in  32  rt operand (multiplier / divisor).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write enables.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  set with `done` when a divide had `src2`==0.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- States:
  - IDLE: on `start`, go to CALC.
  - CALC: 32 iterations, then go to FIX.
  - FIX: commit results, then go to IDLE.
- Start in IDLE:
  - Latch `op`.
  - Latch operand magnitudes. For signed ops, take the absolute value of each negative operand.
  - Record the result sign(s).
  - Clear the counter and the 64-bit accumulator.
- Multiply (CALC): radix-2 shift-add, one multiplier bit per cycle, LSB first. The accumulator holds a 64-bit product.
- Divide (CALC): restoring division, one quotient bit per cycle, MSB first. The accumulator holds {remainder, quotient}.
- FIX stage:
  - Apply sign correction. A signed product is negated if the operand signs differ.
  - A signed quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Write HI/LO:
    - Multiply: hi = product[63:32], lo = product[31:0].
    - Divide: hi = remainder, lo = quotient.
  - Pulse `done`.
- Divide by zero:
  - Full latency.
  - lo = 0xFFFFFFFF, hi = `src1` as latched, signedness ignored.
  - `div_zero`=1 with `done`.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Wraps; no flag.
- `start` while busy: ignored.
- `hi_we`/`lo_we`:
  - In IDLE without `start`: write `wdata` at the edge.
  - While busy, or in the same cycle as an accepted `start`: dropped.
- `hi`/`lo` hold their value between completions.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state = IDLE.
  - `busy`=0, `done`=0, `div_zero`=0.
  - `hi`=0, `lo`=0.
  - Counter and accumulator = 0.
- Reset mid-operation aborts the operation. HI/LO clear to 0, and no `done` is generated.
- `start` accepted at edge E0 → `busy`=1 from after E0.
- CALC covers edges E1..E32. FIX is at edge E33.
- After E33: `done`=1 for exactly one cycle, `busy`=0, and `hi`/`lo` hold the new values in that same cycle.
- Total latency is 34 cycles from the `start` edge to `done`.
- A new `start` may be accepted in the `done` cycle (back-to-back issue).
- `div_zero` is valid only while `done`=1; it is 0 otherwise.
- `busy` is registered with no combinational path from `start`. The control unit must stall for the cycle in which it asserts `start`.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: DIV/DIVU behave as specified above.
  - Undefined: the divide datapath is not built. DIV/DIVU are accepted as no-ops:
    - `busy` is high for one cycle, then `done` pulses.
    - `hi`/`lo` are unchanged and `div_zero`=0.
    - Total latency is 2 cycles.
  - Multiply behaviour is identical in both builds.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles → `hi`=`lo`=0, `busy`=`done`=0.
- MULT 0xFFFFFFFF × 0x00000002 → after 34 cycles `lo`=0xFFFFFFFE, `hi`=0xFFFFFFFF. The same operands with MULTU → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV −7 / 2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU 100 / 7 → `lo`=14, `hi`=2.
- DIVU 0x1234 / 0 → at `done`: `div_zero`=1, `lo`=0xFFFFFFFF, `hi`=0x1234.
- Busy-cycle stimulus:
  - `start` pulsed mid-operation is ignored; exactly one `done` is observed.
  - `hi_we` with `wdata`=0xA5A5A5A5 during busy is dropped.
  - After return to IDLE, the same write lands: `hi`=0xA5A5A5A5.
- Abort: `rst_n`=0 at cycle 10 of a MULT → no `done`, `hi`=`lo`=0. A following MULTU 3×5 yields `lo`=15.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU use radix-2 shift-add (LSB first); DIV/DIVU use restoring
// division (MSB first). Both run 32 iterations in CALC, then sign-fix in FIX.
// Build option: define MULDIV_DIV_EN to build the divide datapath; without it
// DIV/DIVU complete as 2-cycle no-ops that leave HI/LO untouched.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic               neg_q;

  logic               is_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic               neg_r;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  assign busy = (state != S_IDLE);

  // Operand magnitudes at launch and the per-iteration / final datapaths.
  always_comb begin
    is_signed = ~op[0];
    a_abs     = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
    b_abs     = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
    // Add to the upper half, then shift the 65-bit {carry, acc} right by one.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    prod_fix  = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
    // Remainder sits in acc upper half; dividend bits enter from a_q's MSB.
    rem_sh    = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, b_q};
    q_bit     = (rem_sh >= {1'b0, b_q});
    rem_new   = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_next  = {rem_new, acc[WIDTH-2:0], q_bit};
    quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // With a zero divisor the remainder ends as |src1|, so re-applying the
    // dividend's sign reproduces src1 exactly for both DIV and DIVU.
    rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif
  end

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r    <= 1'b0;
`endif
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            a_q      <= a_abs;
            b_q      <= b_abs;
            neg_q    <= is_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            neg_r    <= is_signed & src1[WIDTH-1];
            state    <= S_CALC;
`else
            state    <= op[1] ? S_FIX : S_CALC;
`endif
            cnt      <= '0;
            acc      <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            acc <= div_next;
            a_q <= a_q << 1;
          end else
`endif
          begin
            acc <= mul_next;
            b_q <= b_q >> 1;
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi <= rem_fix;
            if (b_q == '0) begin
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              lo <= quot_fix;
            end
          end else
`else
          if (!is_div_q)
`endif
          begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int base;
  int n;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int MUL_LAT = 33;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Entered just after a negedge; issues one operation and checks completion.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_dz, input int e_lat);
    int k;
    op = o; src1 = a; src2 = b; start = 1'b1;
    cycle();
    start = 1'b0;
    chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    k = 0;
    while (done !== 1'b1 && k < 80) begin
      cycle();
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'(e_lat));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".hi"}, hi, e_hi);
    chk({tag, ".lo"}, lo, e_lo);
    chk({tag, ".div_zero"}, 32'(div_zero), 32'(e_dz));
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic run_div(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input logic e_dz);
`ifdef MULDIV_DIV_EN
    run_op(tag, o, a, b, e_hi, e_lo, e_dz, MUL_LAT);
`else
    run_op(tag, o, a, b, m_hi, m_lo, 1'b0, 1);
`endif
  endtask

  initial begin
    // Reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Multiplies
    run_op("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
    cycle();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold.hi", hi, 32'hFFFF_FFFF);
    run_op("multu_ffx2", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
    // Issued in the done cycle of the previous op
    run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, MUL_LAT);
    run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_LAT);
    cycle();

    // Divides
    run_div("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_div("divu_by0", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    cycle();
    chk("div_zero_clears", 32'(div_zero), 32'd0);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_div("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_div("div_m5by0", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    cycle();

    // Start and MTHI during busy are ignored
    base = done_cnt;
    op = OP_MULTU; src1 = 32'h1234_5678; src2 = 32'h10; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    start = 1'b1; op = OP_DIVU; src1 = 32'hFFFF_0000; src2 = 32'h3;
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    cycle();
    start = 1'b0; hi_we = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      cycle();
      n++;
    end
    chk("busy_ign.done", 32'(done), 32'd1);
    chk("busy_ign.hi", hi, 32'h1);
    chk("busy_ign.lo", lo, 32'h2345_6780);
    repeat (40) cycle();
    chk("busy_ign.done_count", 32'(done_cnt - base), 32'd1);

    // Same writes land in IDLE
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    cycle();
    hi_we = 1'b0;
    chk("mthi.hi", hi, 32'hA5A5_A5A5);
    chk("mthi.lo", lo, 32'h2345_6780);
    lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    cycle();
    lo_we = 1'b0;
    chk("mtlo.lo", lo, 32'h5A5A_5A5A);
    chk("mtlo.hi", hi, 32'hA5A5_A5A5);

    // Reset in the middle of a MULT
    op = OP_MULT; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (9) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("abort.hi", hi, 32'h0);
    chk("abort.lo", lo, 32'h0);
    chk("abort.busy", 32'(busy), 32'd0);
    base = done_cnt;
    repeat (40) cycle();
    chk("abort.no_done", 32'(done_cnt - base), 32'd0);
    m_hi = '0; m_lo = '0;
    run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, MUL_LAT);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
